// File: rtl/mem_exec_unit_pkg.sv
// Shared types and constants for the memory execution unit and its issue queue.
package mem_exec_unit_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned IQ_DEPTH = 8;
   localparam int unsigned IQPOS_W  = $clog2(IQ_DEPTH);
   localparam int unsigned IMM_W    = 16;
   localparam int unsigned RD_W     = 5;

   typedef enum logic [1:0] {
      MEMOP_LW  = 2'b00,
      MEMOP_SW  = 2'b01,
      MEMOP_LB  = 2'b10,
      MEMOP_LBU = 2'b11
   } memop_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WB    = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   // Fields of the accepted packet still needed after the memory phase.
   typedef struct packed {
      memop_e               op;
      logic [IQPOS_W-1:0]   iqpos;
      logic [RD_W-1:0]      rd;
      logic [1:0]           ea_lo;
   } mem_pkt_t;

   // Effective address: base plus sign-extended offset, wrapping.
   function automatic logic [XLEN-1:0] calc_ea(input logic [XLEN-1:0] base,
                                               input logic [IMM_W-1:0] imm);
      return base + {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

   // Word accesses must be 4-byte aligned; byte accesses never fault.
   function automatic logic is_misaligned(input memop_e op, input logic [1:0] ea_lo);
      return ((op == MEMOP_LW) || (op == MEMOP_SW)) && (ea_lo != 2'b00);
   endfunction

endpackage

// File: rtl/mem_exec_unit_if.sv
// Issue, data-memory and writeback buses of the memory execution unit.
interface mem_exec_unit_if;
   import mem_exec_unit_pkg::*;

   logic                 issue_valid;
   logic                 issue_ready;
   logic [1:0]           issue_op;
   logic [IQPOS_W-1:0]   issue_iqpos;
   logic [RD_W-1:0]      issue_rd;
   logic [XLEN-1:0]      issue_base;
   logic [IMM_W-1:0]     issue_imm;
   logic [XLEN-1:0]      issue_sdata;

   logic                 mem_req;
   logic                 mem_we;
   logic [XLEN-1:0]      mem_addr;
   logic [XLEN-1:0]      mem_wdata;
   logic                 mem_gnt;
   logic                 mem_rvalid;
   logic [XLEN-1:0]      mem_rdata;

   logic                 wb_valid;
   logic                 wb_ack;
   logic [IQPOS_W-1:0]   wb_iqpos;
   logic [RD_W-1:0]      wb_rd;
   logic [XLEN-1:0]      wb_value;
   logic                 wb_exc;

   // The execution unit itself.
   modport slave (
      input  issue_valid, issue_op, issue_iqpos, issue_rd, issue_base, issue_imm, issue_sdata,
      output issue_ready,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output wb_valid, wb_iqpos, wb_rd, wb_value, wb_exc,
      input  wb_ack
   );

   // Surroundings: issue queue, data memory and writeback consumer.
   modport master (
      output issue_valid, issue_op, issue_iqpos, issue_rd, issue_base, issue_imm, issue_sdata,
      input  issue_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  wb_valid, wb_iqpos, wb_rd, wb_value, wb_exc,
      output wb_ack
   );

endinterface

// File: rtl/mem_load_align.sv
// Selects and extends the loaded data according to op and byte offset.
module mem_load_align
   import mem_exec_unit_pkg::*;
(
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      ea_lo_i,
   input  memop_e          op_i,
   output logic [XLEN-1:0] value_o
);

   logic [7:0] byte_sel;

   // Byte lane pick followed by sign/zero extension.
   always_comb begin
      byte_sel = 8'h00;
      value_o  = '0;
      case (ea_lo_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      case (op_i)
         MEMOP_LW:  value_o = rdata_i;
         MEMOP_LB:  value_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         MEMOP_LBU: value_o = {{(XLEN-8){1'b0}}, byte_sel};
         default:   value_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_exec_unit.sv
// Single-outstanding load/store unit between the IQ mem scheduler and data memory.
module mem_exec_unit
   import mem_exec_unit_pkg::*;
(
   input  logic            clk,
   input  logic            nrst,
   input  logic            flush,
   mem_exec_unit_if.slave  bus
);

   state_e              state_q;
   mem_pkt_t            pkt_q;
   logic                req_q, we_q;
   logic [XLEN-1:0]     addr_q, wdata_q;
   logic [XLEN-1:0]     res_q;
   logic                res_exc_q;
   logic                wbv_q, wbexc_q;
   logic [XLEN-1:0]     wbval_q;
   logic [IQPOS_W-1:0]  wbpos_q;
   logic [RD_W-1:0]     wbrd_q;

   logic [XLEN-1:0]     ea_d;
   memop_e              op_d;
   logic [XLEN-1:0]     ld_val;

   assign op_d = memop_e'(bus.issue_op);
   assign ea_d = calc_ea(bus.issue_base, bus.issue_imm);

   mem_load_align u_align (
      .rdata_i (bus.mem_rdata),
      .ea_lo_i (pkt_q.ea_lo),
      .op_i    (pkt_q.op),
      .value_o (ld_val)
   );

   // Ready is the only combinational output: it must drop in the flush cycle itself.
   assign bus.issue_ready = nrst & ~flush & (state_q == ST_IDLE);
   assign bus.mem_req     = req_q;
   assign bus.mem_we      = we_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.wb_valid    = wbv_q;
   assign bus.wb_exc      = wbexc_q;
   assign bus.wb_value    = wbval_q;
   assign bus.wb_iqpos    = wbpos_q;
   assign bus.wb_rd       = wbrd_q;

   // Issue acceptance, memory handshake and writeback sequencing; flush wins every cycle.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q   <= ST_IDLE;
         pkt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         res_q     <= '0;
         res_exc_q <= 1'b0;
         wbv_q     <= 1'b0;
         wbexc_q   <= 1'b0;
         wbval_q   <= '0;
         wbpos_q   <= '0;
         wbrd_q    <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.issue_valid && !flush) begin
                  pkt_q.op    <= op_d;
                  pkt_q.iqpos <= bus.issue_iqpos;
                  pkt_q.rd    <= bus.issue_rd;
                  pkt_q.ea_lo <= ea_d[1:0];
                  if (is_misaligned(op_d, ea_d[1:0])) begin
                     res_q     <= '0;
                     res_exc_q <= 1'b1;
                     state_q   <= ST_WB;
                  end else begin
                     req_q   <= 1'b1;
                     we_q    <= (op_d == MEMOP_SW);
                     addr_q  <= {ea_d[XLEN-1:2], 2'b00};
                     wdata_q <= bus.issue_sdata;
                     state_q <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               // A grant commits the access even when flushed in the same cycle.
               if (bus.mem_gnt) begin
                  req_q <= 1'b0;
                  we_q  <= 1'b0;
                  if (pkt_q.op == MEMOP_SW) begin
                     if (flush) begin
                        state_q <= ST_IDLE;
                     end else begin
                        res_q     <= '0;
                        res_exc_q <= 1'b0;
                        state_q   <= ST_WB;
                     end
                  end else begin
                     state_q <= flush ? ST_DRAIN : ST_WAIT;
                  end
               end else if (flush) begin
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (flush) begin
                  state_q <= bus.mem_rvalid ? ST_IDLE : ST_DRAIN;
               end else if (bus.mem_rvalid) begin
                  res_q     <= ld_val;
                  res_exc_q <= 1'b0;
                  state_q   <= ST_WB;
               end
            end
            ST_DRAIN: begin
               if (bus.mem_rvalid) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_WB: begin
               // Result is presented one cycle after entering WB, then held until ack.
               if (flush || (wbv_q && bus.wb_ack)) begin
                  wbv_q   <= 1'b0;
                  wbexc_q <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (!wbv_q) begin
                  wbv_q   <= 1'b1;
                  wbexc_q <= res_exc_q;
                  wbval_q <= res_q;
                  wbpos_q <= pkt_q.iqpos;
                  wbrd_q  <= pkt_q.rd;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_exec_unit.md
Name: mem_exec_unit

Overview:
Receiving end of the memory issue bus. It accepts one load/store packet from the issue queue and computes the effective address. It performs the access over a req/gnt/rvalid data-memory interface. It then broadcasts the result on a writeback port, tagged with the originating IQ slot, so the IQ can clear the slot and wake dependents. It is single-outstanding and sits between the IQ mem scheduler and data memory.

Parameters:
XLEN, 32, datapath and address width
IQ_DEPTH, 8, issue-queue entries
IQPOS_W, 3, width of the IQ slot tag (log2 IQ_DEPTH)

Ports:
clk  in  1  system clock; all state changes on posedge
nrst  in  1  synchronous active-low reset
flush  in  1  squash the in-flight op and ignore any issue this cycle
issue_valid  in  1  issue packet valid
issue_ready  out  1  unit can accept a packet this cycle
issue_op  in  2  00 LW, 01 SW, 10 LB, 11 LBU
issue_iqpos  in  IQPOS_W  originating IQ slot
issue_rd  in  5  destination register (ignored for SW)
issue_base  in  XLEN  rs1 value
issue_imm  in  16  offset, sign-extended
issue_sdata  in  XLEN  store data (rs2 value)
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  XLEN  word-aligned address ({ea[XLEN-1:2],2'b00})
mem_wdata  out  XLEN  store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  XLEN  read data
wb_valid  out  1  writeback valid
wb_ack  in  1  writeback consumed
wb_iqpos  out  IQPOS_W  slot tag
wb_rd  out  5  destination register
wb_value  out  XLEN  load result; 0 for SW
wb_exc  out  1  misaligned-access exception

Behaviour:
- Reset (nrst=0 at posedge): state IDLE. mem_req, mem_we, wb_valid and wb_exc are 0. mem_addr, mem_wdata, wb_value, wb_iqpos and wb_rd are 0. issue_ready is 0 while nrst=0 and 1 in IDLE after reset. A reset mid-operation abandons the op; a later mem_rvalid is ignored in IDLE.
- Effective address ea = issue_base + sext(issue_imm), modulo 2^XLEN (wrap, no overflow flag).
- States: IDLE, REQ, WAIT, WB, DRAIN.
- IDLE: issue_ready = ~flush. On issue_valid & issue_ready, latch the packet and ea.
  - LW/SW with ea[1:0]!=0 -> WB with wb_exc=1, wb_value=0, no memory access.
  - Otherwise -> REQ.
- REQ: hold mem_req=1 and stable mem_addr/mem_we/mem_wdata until mem_gnt.
  - On gnt, a load -> WAIT; a store -> WB with wb_value=0.
- WAIT: on mem_rvalid, form the result and go to WB.
  - LW: rdata.
  - LB/LBU: byte rdata[8*ea[1:0]+7 -:8], sign- or zero-extended.
  - Byte loads have no alignment check.
- WB: hold wb_valid=1 and stable payload until wb_ack; then -> IDLE.
  - No new issue is accepted in the ack cycle (issue_ready is 0 outside IDLE).
- Flush (priority over all other events in the same cycle):
  - IDLE: the issue is dropped.
  - REQ: -> IDLE with mem_req=0 next cycle. If mem_gnt coincides with flush, the access is already committed: a load -> DRAIN, a store completes at memory with no writeback.
  - WAIT: -> DRAIN, or -> IDLE if mem_rvalid is in the same cycle.
  - DRAIN: wait for mem_rvalid, discard the data, -> IDLE, no writeback.
  - WB: wb_valid drops next cycle, -> IDLE, even if wb_ack coincides.
- Minimum latency: issue accepted at posedge N; mem_req is high after N.
  - gnt in that cycle and rvalid in the next: wb_valid high after N+3.
  - Misaligned: wb_valid high after N+1.
- Exactly one writeback per accepted, un-flushed issue; none for flushed ops.

Decomposition:
- Shared defines header:
  - op encodings (MEMOP_LW/SW/LB/LBU)
  - FSM state encoding (3 bits)
  - IQPOS_W / IQ_DEPTH constants shared with the issue queue
- One combinational sub-module, mem_load_align: inputs rdata, ea[1:0] and op; output extended value.

Test Plan:
- LW: base=0x1000, imm=0xFFFC; gnt same cycle, rvalid next with rdata=0xDEADBEEF -> mem_addr=0x0FFC, mem_we=0; wb_value=0xDEADBEEF, wb_iqpos as issued, wb_valid after N+3.
- LB/LBU: ea=0x2003, rdata=0x80112233 -> LB gives wb_value=0xFFFFFF80; LBU gives 0x00000080.
- SW misaligned: base=0x2001, imm=0 -> no mem_req ever; wb_valid after N+1 with wb_exc=1, wb_value=0. SW aligned with gnt delayed 3 cycles -> mem_req and payload stable 4 cycles, mem_we=1, mem_wdata=sdata.
- Flush in WAIT, rvalid 2 cycles later -> no wb_valid; issue_ready returns 1 the cycle after rvalid; next issued LW completes normally.
- wb_ack withheld 5 cycles -> wb_valid and payload stable, issue_ready=0 throughout. issue_valid together with flush in IDLE -> packet ignored, no mem_req.
- nrst=0 while in WAIT -> all outputs 0 next cycle; a stray mem_rvalid afterwards produces no wb_valid.
